max_pool_layer: RTL and testbench

MAX_POOL_LAYER -- requirements
Module: max_pool_layer

---
 rtl/max_pool_layer.sv | 93 +++++++++
 tb/tb_max_pool_layer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_layer.sv
// Streaming 1-D max pooling over NUM_INPUTS signed channels, window = stride = POOL_SIZE.
// Optional MAX_POOL_LAYER_FLUSH_EN adds max_pool_layer_flush to emit a partial window early.
module max_pool_layer #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_INPUTS = 5,
  parameter int POOL_SIZE  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MAX_POOL_LAYER_FLUSH_EN
  input  logic                  max_pool_layer_flush,
`endif
  output logic                  max_pool_layer_ready_in,
  input  logic [NUM_INPUTS-1:0] max_pool_layer_valid_in,
  input  logic [DATA_WIDTH-1:0] max_pool_layer_data_in [0:NUM_INPUTS-1],
  input  logic                  max_pool_layer_ready_out,
  output logic [NUM_INPUTS-1:0] max_pool_layer_valid_out,
  output logic [DATA_WIDTH-1:0] max_pool_layer_data_out [0:NUM_INPUTS-1]
);

  localparam int CW = $clog2(POOL_SIZE);
  localparam logic [CW-1:0] LAST = CW'(POOL_SIZE - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] max_q [0:NUM_INPUTS-1];
  logic [DATA_WIDTH-1:0] max_d [0:NUM_INPUTS-1];
  logic [DATA_WIDTH-1:0] out_q [0:NUM_INPUTS-1];
  logic [DATA_WIDTH-1:0] out_d [0:NUM_INPUTS-1];
  logic [DATA_WIDTH-1:0] win   [0:NUM_INPUTS-1];
  logic                  ready_in;
  logic                  accept;
  logic                  flush_w;
  logic                  done;

`ifdef MAX_POOL_LAYER_FLUSH_EN
  assign flush_w = max_pool_layer_flush;
`else
  assign flush_w = 1'b0;
`endif

  assign ready_in = !(valid_q && !max_pool_layer_ready_out);
  assign accept   = ready_in && (&max_pool_layer_valid_in);

  // A flush only fires when there is something in the window to emit.
  assign done = (accept && (cnt_q == LAST)) ||
                (flush_w && ready_in && ((cnt_q != '0) || accept));

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      win[i]   = max_q[i];
      max_d[i] = max_q[i];
      out_d[i] = out_q[i];
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (accept && ((cnt_q == '0) ||
          ($signed(max_pool_layer_data_in[i]) > $signed(max_q[i])))) begin
        win[i] = max_pool_layer_data_in[i];
      end
      if (accept) max_d[i] = win[i];
      if (done)   out_d[i] = win[i];
    end
    if (done)        cnt_d = '0;
    else if (accept) cnt_d = cnt_q + CW'(1);
    if (done)                                   valid_d = 1'b1;
    else if (valid_q && max_pool_layer_ready_out) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        max_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        max_q[i] <= max_d[i];
        out_q[i] <= out_d[i];
      end
    end
  end

  assign max_pool_layer_ready_in  = ready_in;
  assign max_pool_layer_valid_out = {NUM_INPUTS{valid_q}};
  assign max_pool_layer_data_out  = out_q;

endmodule

// File: tb/tb_max_pool_layer.sv
// Directed bench for max_pool_layer (POOL_SIZE=2, 5 channels, 12-bit).
// With MAX_POOL_LAYER_FLUSH_EN a second POOL_SIZE=4 instance exercises flush.
module tb_max_pool_layer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_in;
  logic [4:0]  valid_in;
  logic [11:0] data_in  [0:4];
  logic        ready_out;
  logic [4:0]  valid_out;
  logic [11:0] data_out [0:4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef MAX_POOL_LAYER_FLUSH_EN
  logic        f_flush;
  logic        f_ready_in;
  logic [4:0]  f_valid_in;
  logic [11:0] f_data_in  [0:4];
  logic [4:0]  f_valid_out;
  logic [11:0] f_data_out [0:4];
  logic        zero_flush = 1'b0;

  max_pool_layer #(.DATA_WIDTH(12), .NUM_INPUTS(5), .POOL_SIZE(4)) u_dut4 (
    .clk                      (clk),
    .rst                      (rst),
    .max_pool_layer_flush     (f_flush),
    .max_pool_layer_ready_in  (f_ready_in),
    .max_pool_layer_valid_in  (f_valid_in),
    .max_pool_layer_data_in   (f_data_in),
    .max_pool_layer_ready_out (1'b1),
    .max_pool_layer_valid_out (f_valid_out),
    .max_pool_layer_data_out  (f_data_out)
  );
`endif

  max_pool_layer #(.DATA_WIDTH(12), .NUM_INPUTS(5), .POOL_SIZE(2)) u_dut (
    .clk                      (clk),
    .rst                      (rst),
`ifdef MAX_POOL_LAYER_FLUSH_EN
    .max_pool_layer_flush     (zero_flush),
`endif
    .max_pool_layer_ready_in  (ready_in),
    .max_pool_layer_valid_in  (valid_in),
    .max_pool_layer_data_in   (data_in),
    .max_pool_layer_ready_out (ready_out),
    .max_pool_layer_valid_out (valid_out),
    .max_pool_layer_data_out  (data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v, input logic [11:0] d0,
                       input logic [11:0] d1, input logic [11:0] d2,
                       input logic [11:0] d3, input logic [11:0] d4);
    @(negedge clk);
    valid_in   = v;
    data_in[0] = d0;
    data_in[1] = d1;
    data_in[2] = d2;
    data_in[3] = d3;
    data_in[4] = d4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    ready_out = 1'b1;
    valid_in  = '0;
    for (int i = 0; i < 5; i++) data_in[i] = '0;
`ifdef MAX_POOL_LAYER_FLUSH_EN
    f_flush    = 1'b0;
    f_valid_in = '0;
    for (int i = 0; i < 5; i++) f_data_in[i] = '0;
`endif
    tick();
    tick();
    check("rst_valid", 32'(valid_out), 32'h00);
    check("rst_data0", 32'(data_out[0]), 32'h000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready_in", 32'(ready_in), 32'h1);

    // basic window {5,9}, mixed-sign other channels
    drive(5'h1F, 12'd5, 12'hFFF, 12'd100, 12'h7FF, 12'h800);
    tick();
    check("w1_beat1_valid", 32'(valid_out), 32'h00);
    drive(5'h1F, 12'd9, 12'hFFE, 12'd50, 12'h000, 12'h801);
    tick();
    check("w1_valid", 32'(valid_out), 32'h1F);
    check("w1_ch0", 32'(data_out[0]), 32'h009);
    check("w1_ch1", 32'(data_out[1]), 32'hFFF);
    check("w1_ch2", 32'(data_out[2]), 32'd100);
    check("w1_ch3", 32'(data_out[3]), 32'h7FF);
    check("w1_ch4", 32'(data_out[4]), 32'h801);

    // signed max of negatives, equal values on ch1
    drive(5'h1F, 12'hFFD, 12'd7, 12'd1, 12'd1, 12'd1);
    tick();
    check("w2_consumed", 32'(valid_out), 32'h00);
    drive(5'h1F, 12'hFF9, 12'd7, 12'd2, 12'd0, 12'hFFF);
    tick();
    check("w2_valid", 32'(valid_out), 32'h1F);
    check("w2_ch0", 32'(data_out[0]), 32'hFFD);
    check("w2_ch1", 32'(data_out[1]), 32'd7);

    // backpressure: output held, input stalled
    @(negedge clk);
    ready_out = 1'b0;
    drive(5'h1F, 12'd20, 12'd0, 12'd0, 12'd0, 12'd0);
    #1;
    check("bp_ready_in0", 32'(ready_in), 32'h0);
    tick();
    check("bp_hold_valid", 32'(valid_out), 32'h1F);
    check("bp_hold_data", 32'(data_out[0]), 32'hFFD);
    drive(5'h1F, 12'd30, 12'd0, 12'd0, 12'd0, 12'd0);
    tick();
    check("bp_hold_data2", 32'(data_out[0]), 32'hFFD);
    drive(5'h1F, 12'd20, 12'd0, 12'd0, 12'd0, 12'd0);
    ready_out = 1'b1;
    #1;
    check("bp_ready_in1", 32'(ready_in), 32'h1);
    tick();
    check("bp_drained", 32'(valid_out), 32'h00);
    drive(5'h1F, 12'd30, 12'd0, 12'd0, 12'd0, 12'd0);
    tick();
    check("bp_next_valid", 32'(valid_out), 32'h1F);
    check("bp_next_data", 32'(data_out[0]), 32'd30);

    // partial valid is ignored
    for (int k = 0; k < 3; k++) begin
      drive(5'h1E, 12'd100, 12'd100, 12'd100, 12'd100, 12'd100);
      tick();
      check("partial_no_out", 32'(valid_out), 32'h00);
    end
    drive(5'h1F, 12'd3, 12'd0, 12'd0, 12'd0, 12'd0);
    tick();
    check("partial_cnt0", 32'(valid_out), 32'h00);
    drive(5'h1F, 12'd1, 12'd0, 12'd0, 12'd0, 12'd0);
    tick();
    check("partial_valid", 32'(valid_out), 32'h1F);
    check("partial_data", 32'(data_out[0]), 32'd3);

    // reset discards a half window and wins over a handshake
    drive(5'h1F, 12'd77, 12'd0, 12'd0, 12'd0, 12'd0);
    tick();
    check("prerst_valid", 32'(valid_out), 32'h00);
    drive(5'h1F, 12'd88, 12'd0, 12'd0, 12'd0, 12'd0);
    rst = 1'b1;
    tick();
    check("rst2_valid", 32'(valid_out), 32'h00);
    check("rst2_data", 32'(data_out[0]), 32'h000);
    drive(5'h00, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
    rst = 1'b0;
    #1;
    check("rst2_ready_in", 32'(ready_in), 32'h1);
    drive(5'h1F, 12'd1, 12'd0, 12'd0, 12'd0, 12'd0);
    tick();
    check("postrst_beat1", 32'(valid_out), 32'h00);
    drive(5'h1F, 12'd2, 12'd0, 12'd0, 12'd0, 12'd0);
    tick();
    check("postrst_valid", 32'(valid_out), 32'h1F);
    check("postrst_data", 32'(data_out[0]), 32'd2);
    drive(5'h00, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
    tick();
    check("postrst_clear", 32'(valid_out), 32'h00);

`ifdef MAX_POOL_LAYER_FLUSH_EN
    @(negedge clk);
    f_flush = 1'b1;
    tick();
    check("fl_idle_noop", 32'(f_valid_out), 32'h00);
    @(negedge clk);
    f_flush    = 1'b0;
    f_valid_in = 5'h1F;
    f_data_in[0] = 12'd4;
    tick();
    @(negedge clk);
    f_data_in[0] = 12'd8;
    tick();
    check("fl_partial_none", 32'(f_valid_out), 32'h00);
    @(negedge clk);
    f_valid_in = 5'h00;
    f_flush    = 1'b1;
    tick();
    check("fl_valid", 32'(f_valid_out), 32'h1F);
    check("fl_data", 32'(f_data_out[0]), 32'd8);
    @(negedge clk);
    f_flush    = 1'b0;
    f_valid_in = 5'h1F;
    f_data_in[0] = 12'd1;
    tick();
    check("fl_cnt0_a", 32'(f_valid_out), 32'h00);
    @(negedge clk);
    f_data_in[0] = 12'd2;
    tick();
    @(negedge clk);
    f_data_in[0] = 12'd3;
    tick();
    check("fl_cnt0_b", 32'(f_valid_out), 32'h00);
    @(negedge clk);
    f_data_in[0] = 12'd5;
    tick();
    check("fl_full_valid", 32'(f_valid_out), 32'h1F);
    check("fl_full_data", 32'(f_data_out[0]), 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
